// File: rtl/mips_alu.sv
// mips_alu: execute-stage ALU for a single-cycle MIPS-I core.
// Decodes the instruction word, produces a combinational result, zero flag
// and B-operand source select, and owns the architectural HI/LO registers.
// Optional macro ALU_DIV_EN: when defined, DIV/DIVU use a combinational
// divider; when undefined no divider exists and DIV/DIVU behave as NOPs.
module mips_alu (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic [31:0] alu_a,
   input  logic [31:0] alu_b,
   output logic [31:0] alu_out,
   output logic        zero,
   output logic        i_type_ALUSrc,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_MEM_LO = 6'h20;
   localparam logic [5:0] OP_MEM_HI = 6'h2E;

   localparam logic [5:0] F_SLL   = 6'h00;
   localparam logic [5:0] F_SRL   = 6'h02;
   localparam logic [5:0] F_SRA   = 6'h03;
   localparam logic [5:0] F_SLLV  = 6'h04;
   localparam logic [5:0] F_SRLV  = 6'h06;
   localparam logic [5:0] F_SRAV  = 6'h07;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
`ifdef ALU_DIV_EN
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
`endif
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_ADDU  = 6'h21;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_SUBU  = 6'h23;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_XOR   = 6'h26;
   localparam logic [5:0] F_NOR   = 6'h27;
   localparam logic [5:0] F_SLT   = 6'h2A;
   localparam logic [5:0] F_SLTU  = 6'h2B;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;
   logic        unused_fields;

   logic [31:0] result;
   logic        b_is_imm;

   logic signed [63:0] a_s64;
   logic signed [63:0] b_s64;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;

   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   assign opcode   = instruction[31:26];
   assign funct    = instruction[5:0];
   assign shamt    = instruction[10:6];
   assign imm      = instruction[15:0];
   assign imm_sext = {{16{imm[15]}}, imm};
   assign imm_zext = {16'd0, imm};

   // Register-specifier fields are resolved by the register file, not here.
   assign unused_fields = ^instruction[25:16];

   // Full-width products; operands are widened explicitly so the low 64 bits are exact.
   assign a_s64  = {{32{alu_a[31]}}, alu_a};
   assign b_s64  = {{32{alu_b[31]}}, alu_b};
   assign prod_s = a_s64 * b_s64;
   assign prod_u = {32'd0, alu_a} * {32'd0, alu_b};

`ifdef ALU_DIV_EN
   // Signed divide is done on magnitudes so 0x80000000 / -1 needs no special case:
   // the magnitude 0x80000000 divides by 1 and the signs cancel.
   logic        div_signed;
   logic [31:0] dvd_mag, dvs_mag, dvs_safe, q_mag, r_mag, div_q, div_r;

   assign div_signed = (funct == F_DIV);
   assign dvd_mag    = (div_signed && alu_a[31]) ? (32'd0 - alu_a) : alu_a;
   assign dvs_mag    = (div_signed && alu_b[31]) ? (32'd0 - alu_b) : alu_b;
   assign dvs_safe   = (dvs_mag == 32'd0) ? 32'd1 : dvs_mag;
   assign q_mag      = dvd_mag / dvs_safe;
   assign r_mag      = dvd_mag % dvs_safe;
   assign div_q      = (div_signed && (alu_a[31] ^ alu_b[31])) ? (32'd0 - q_mag) : q_mag;
   assign div_r      = (div_signed && alu_a[31]) ? (32'd0 - r_mag) : r_mag;
`endif

   // Decode and compute the combinational result and B-operand source.
   always_comb begin
      result   = 32'd0;
      b_is_imm = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               F_SLL:   result = alu_b << shamt;
               F_SRL:   result = alu_b >> shamt;
               F_SRA:   result = $unsigned($signed(alu_b) >>> shamt);
               F_SLLV:  result = alu_b << alu_a[4:0];
               F_SRLV:  result = alu_b >> alu_a[4:0];
               F_SRAV:  result = $unsigned($signed(alu_b) >>> alu_a[4:0]);
               F_MFHI:  result = hi_q;
               F_MFLO:  result = lo_q;
               F_MTHI,
               F_MTLO:  result = alu_a;
               F_MULT:  result = prod_s[31:0];
               F_MULTU: result = prod_u[31:0];
               F_ADD,
               F_ADDU:  result = alu_a + alu_b;
               F_SUB,
               F_SUBU:  result = alu_a - alu_b;
               F_AND:   result = alu_a & alu_b;
               F_OR:    result = alu_a | alu_b;
               F_XOR:   result = alu_a ^ alu_b;
               F_NOR:   result = ~(alu_a | alu_b);
               F_SLT:   result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
               F_SLTU:  result = {31'd0, (alu_a < alu_b)};
               default: result = 32'd0;
            endcase
         end
         OP_BEQ,
         OP_BNE:   result = alu_a - alu_b;
         OP_ADDI,
         OP_ADDIU: begin
            b_is_imm = 1'b1;
            result   = alu_a + imm_sext;
         end
         OP_SLTI: begin
            b_is_imm = 1'b1;
            result   = {31'd0, ($signed(alu_a) < $signed(imm_sext))};
         end
         OP_SLTIU: begin
            b_is_imm = 1'b1;
            result   = {31'd0, (alu_a < imm_sext)};
         end
         OP_ANDI: begin
            b_is_imm = 1'b1;
            result   = alu_a & imm_zext;
         end
         OP_ORI: begin
            b_is_imm = 1'b1;
            result   = alu_a | imm_zext;
         end
         OP_XORI: begin
            b_is_imm = 1'b1;
            result   = alu_a ^ imm_zext;
         end
         OP_LUI: begin
            b_is_imm = 1'b1;
            result   = {imm, 16'd0};
         end
         default: begin
            if (opcode >= OP_MEM_LO && opcode <= OP_MEM_HI) begin
               b_is_imm = 1'b1;
               result   = alu_a + imm_sext;
            end
         end
      endcase
   end

   // Next HI/LO: hold unless a multiply, divide or move-to writes them.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (opcode == OP_RTYPE) begin
         case (funct)
            F_MTHI:  hi_d = alu_a;
            F_MTLO:  lo_d = alu_a;
            F_MULT:  {hi_d, lo_d} = $unsigned(prod_s);
            F_MULTU: {hi_d, lo_d} = prod_u;
`ifdef ALU_DIV_EN
            F_DIV,
            F_DIVU: begin
               if (alu_b != 32'd0) begin
                  hi_d = div_r;
                  lo_d = div_q;
               end
            end
`endif
            default: begin
               hi_d = hi_q;
               lo_d = lo_q;
            end
         endcase
      end
   end

   // HI/LO registers; reset wins over any write in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign alu_out       = result;
   assign zero          = (result == 32'd0);
   assign i_type_ALUSrc = b_is_imm;
   assign hi            = hi_q;
   assign lo            = lo_q;

endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: self-checking bench for mips_alu (directed vectors plus
// randomized instructions checked against a behavioural reference model).
module tb_mips_alu;

   logic        clk;
   logic        reset;
   logic [31:0] instruction;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_out;
   logic        zero;
   logic        i_type_ALUSrc;
   logic [31:0] hi;
   logic [31:0] lo;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_hi, m_lo;

   logic [5:0] rfuncts [0:24] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h11,
                                  6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21,
                                  6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                                  6'h01};
   logic [5:0] iops [0:15] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                               6'h0E, 6'h0F, 6'h20, 6'h23, 6'h2B, 6'h2E, 6'h02, 6'h3F};

   mips_alu dut (
      .clk           (clk),
      .reset         (reset),
      .instruction   (instruction),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_out       (alu_out),
      .zero          (zero),
      .i_type_ALUSrc (i_type_ALUSrc),
      .hi            (hi),
      .lo            (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input logic rst);
      instruction = ins;
      alu_a       = a;
      alu_b       = b;
      reset       = rst;
      #1;
   endtask

   // Reference combinational behaviour: returns {ALUSrc, result}.
   function automatic logic [32:0] ref_comb(input logic [31:0] ins, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] h,
                                            input logic [31:0] l);
      logic [5:0]  op;
      logic [5:0]  fn;
      longint      sa, sb, simm, t;
      longint unsigned ua, ub, ut;
      logic [31:0] se, ze, out;
      logic        src;
      int          sh;
      op   = ins[31:26];
      fn   = ins[5:0];
      sa   = $signed(a);
      sb   = $signed(b);
      ua   = a;
      ub   = b;
      simm = $signed(ins[15:0]);
      se   = {{16{ins[15]}}, ins[15:0]};
      ze   = {16'd0, ins[15:0]};
      out  = 32'd0;
      src  = 1'b0;
      if (op == 6'h00) begin
         sh = (fn == 6'h04 || fn == 6'h06 || fn == 6'h07) ? int'(a[4:0]) : int'(ins[10:6]);
         case (fn)
            6'h00, 6'h04: out = b << sh;
            6'h02, 6'h06: out = b >> sh;
            6'h03, 6'h07: begin t = sb >>> sh; out = t[31:0]; end
            6'h10: out = h;
            6'h12: out = l;
            6'h11, 6'h13: out = a;
            6'h18: begin t = sa * sb; out = t[31:0]; end
            6'h19: begin ut = ua * ub; out = ut[31:0]; end
            6'h20, 6'h21: begin t = sa + sb; out = t[31:0]; end
            6'h22, 6'h23: begin t = sa - sb; out = t[31:0]; end
            6'h24: out = a & b;
            6'h25: out = a | b;
            6'h26: out = a ^ b;
            6'h27: out = ~(a | b);
            6'h2A: out = (sa < sb) ? 32'd1 : 32'd0;
            6'h2B: out = (ua < ub) ? 32'd1 : 32'd0;
            default: out = 32'd0;
         endcase
      end else if (op == 6'h04 || op == 6'h05) begin
         t = sa - sb; out = t[31:0];
      end else if (op == 6'h08 || op == 6'h09 || (op >= 6'h20 && op <= 6'h2E)) begin
         src = 1'b1; t = sa + simm; out = t[31:0];
      end else if (op == 6'h0A) begin
         src = 1'b1; out = (sa < simm) ? 32'd1 : 32'd0;
      end else if (op == 6'h0B) begin
         src = 1'b1; out = (a < se) ? 32'd1 : 32'd0;
      end else if (op == 6'h0C) begin
         src = 1'b1; out = a & ze;
      end else if (op == 6'h0D) begin
         src = 1'b1; out = a | ze;
      end else if (op == 6'h0E) begin
         src = 1'b1; out = a ^ ze;
      end else if (op == 6'h0F) begin
         src = 1'b1; ut = longint'(ze) * 65536; out = ut[31:0];
      end
      return {src, out};
   endfunction

   // Reference HI/LO update for one clock edge.
   task automatic ref_next(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                           input logic rst, input logic [31:0] h, input logic [31:0] l,
                           output logic [31:0] nh, output logic [31:0] nl);
      longint sa, sb, t;
      longint unsigned ua, ub, ut;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      nh = h;
      nl = l;
      if (rst) begin
         nh = 32'd0;
         nl = 32'd0;
      end else if (ins[31:26] == 6'h00) begin
         case (ins[5:0])
            6'h11: nh = a;
            6'h13: nl = a;
            6'h18: begin t = sa * sb; {nh, nl} = t; end
            6'h19: begin ut = ua * ub; {nh, nl} = ut; end
`ifdef ALU_DIV_EN
            6'h1A: if (b != 32'd0) begin
               t = sa / sb; nl = t[31:0];
               t = sa % sb; nh = t[31:0];
            end
            6'h1B: if (b != 32'd0) begin
               ut = ua / ub; nl = ut[31:0];
               ut = ua % ub; nh = ut[31:0];
            end
`endif
            default: ;
         endcase
      end
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 9))
         0: v = 32'd0;
         1: v = 32'd1;
         2: v = 32'hFFFF_FFFF;
         3: v = 32'h8000_0000;
         4: v = 32'h7FFF_FFFF;
         5: v = $urandom_range(0, 40);
         default: ;
      endcase
      return v;
   endfunction

   task automatic test_reset;
      drive(32'h0000_0011, 32'h1234_5678, 32'h0000_0001, 1'b1);
      checks++;
      if (alu_out !== 32'h1234_5678) begin
         errors++; $display("FAIL reset_comb_mthi: alu_out=%h expected=%h", alu_out, 32'h1234_5678);
      end
      tick;
      checks++;
      if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: hi=%h expected=0", hi); end
      checks++;
      if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: lo=%h expected=0", lo); end
   endtask

   typedef struct {
      logic [31:0] ins;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] out;
      logic        src;
   } vec_t;

   task automatic test_directed;
      vec_t v [0:13];
      v[0]  = '{32'h0000_0025, 32'd5,          32'd2,          32'h0000_0007, 1'b0}; // OR
      v[1]  = '{32'h3400_8000, 32'd5,          32'd0,          32'h0000_8005, 1'b1}; // ORI
      v[2]  = '{32'h3800_FFFF, 32'd5,          32'd0,          32'h0000_FFFA, 1'b1}; // XORI
      v[3]  = '{32'h0000_0023, 32'd5,          32'd2,          32'h0000_0003, 1'b0}; // SUBU
      v[4]  = '{32'h1000_0004, 32'd9,          32'd9,          32'h0000_0000, 1'b0}; // BEQ
      v[5]  = '{32'h0000_002A, 32'hFFFF_FFFF,  32'd1,          32'h0000_0001, 1'b0}; // SLT
      v[6]  = '{32'h0000_002B, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1'b0}; // SLTU
      v[7]  = '{32'h2400_FFFF, 32'd5,          32'd0,          32'h0000_0004, 1'b1}; // ADDIU
      v[8]  = '{32'h3C00_1234, 32'd0,          32'd0,          32'h1234_0000, 1'b1}; // LUI
      v[9]  = '{32'h0000_0103, 32'd0,          32'h8000_0000,  32'hF800_0000, 1'b0}; // SRA 4
      v[10] = '{32'h8C00_FFF0, 32'h0000_0100,  32'd0,          32'h0000_00F0, 1'b1}; // LW
      v[11] = '{32'hFC00_1234, 32'd5,          32'd2,          32'h0000_0000, 1'b0}; // bad op
      v[12] = '{32'h0000_0001, 32'd5,          32'd2,          32'h0000_0000, 1'b0}; // bad funct
      v[13] = '{32'h2C00_8000, 32'h0000_0005,  32'd0,          32'h0000_0001, 1'b1}; // SLTIU
      for (int i = 0; i < 14; i++) begin
         drive(v[i].ins, v[i].a, v[i].b, 1'b0);
         checks++;
         if (alu_out !== v[i].out) begin
            errors++; $display("FAIL directed_out[%0d]: alu_out=%h expected=%h", i, alu_out, v[i].out);
         end
         checks++;
         if (zero !== (v[i].out == 32'd0)) begin
            errors++; $display("FAIL directed_zero[%0d]: zero=%b expected=%b", i, zero, (v[i].out == 32'd0));
         end
         checks++;
         if (i_type_ALUSrc !== v[i].src) begin
            errors++; $display("FAIL directed_src[%0d]: ALUSrc=%b expected=%b", i, i_type_ALUSrc, v[i].src);
         end
      end
   endtask

   task automatic test_mult;
      drive(32'h02D6_0018, 32'hFFFF_FFFB, 32'd2, 1'b0);
      checks++;
      if (alu_out !== 32'hFFFF_FFF6 || i_type_ALUSrc !== 1'b0) begin
         errors++; $display("FAIL mult_comb: alu_out=%h src=%b expected=fffffff6 src=0", alu_out, i_type_ALUSrc);
      end
      tick;
      checks++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF6) begin
         errors++; $display("FAIL mult_hilo: hi=%h lo=%h expected=ffffffff fffffff6", hi, lo);
      end
      drive(32'h02D6_0019, 32'hFFFF_FFFB, 32'd2, 1'b0);
      checks++;
      if (alu_out !== 32'hFFFF_FFF6) begin
         errors++; $display("FAIL multu_comb: alu_out=%h expected=fffffff6", alu_out);
      end
      tick;
      checks++;
      if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFF6) begin
         errors++; $display("FAIL multu_hilo: hi=%h lo=%h expected=00000001 fffffff6", hi, lo);
      end
   endtask

   task automatic test_div;
      logic [31:0] eh, el;
      drive(32'h0000_0011, 32'h1111_1111, 32'd0, 1'b0); tick;
      drive(32'h0000_0013, 32'h2222_2222, 32'd0, 1'b0); tick;
      eh = 32'h1111_1111;
      el = 32'h2222_2222;
      // DIV 7 / -2
      drive(32'h0000_001A, 32'd7, 32'hFFFF_FFFE, 1'b0);
      checks++;
      if (alu_out !== 32'd0 || zero !== 1'b1) begin
         errors++; $display("FAIL div_comb: alu_out=%h zero=%b expected=0 1", alu_out, zero);
      end
      tick;
`ifdef ALU_DIV_EN
      eh = 32'h0000_0001; el = 32'hFFFF_FFFD;
`endif
      checks++;
      if (hi !== eh || lo !== el) begin
         errors++; $display("FAIL div_signed: hi=%h lo=%h expected=%h %h", hi, lo, eh, el);
      end
      // DIV by zero holds
      drive(32'h0000_001A, 32'd99, 32'd0, 1'b0); tick;
      checks++;
      if (hi !== eh || lo !== el) begin
         errors++; $display("FAIL div_zero: hi=%h lo=%h expected=%h %h", hi, lo, eh, el);
      end
      // DIVU by zero holds
      drive(32'h0000_001B, 32'd99, 32'd0, 1'b0); tick;
      checks++;
      if (hi !== eh || lo !== el) begin
         errors++; $display("FAIL divu_zero: hi=%h lo=%h expected=%h %h", hi, lo, eh, el);
      end
      // Most-negative / -1
      drive(32'h0000_001A, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); tick;
`ifdef ALU_DIV_EN
      eh = 32'd0; el = 32'h8000_0000;
`endif
      checks++;
      if (hi !== eh || lo !== el) begin
         errors++; $display("FAIL div_overflow: hi=%h lo=%h expected=%h %h", hi, lo, eh, el);
      end
      // DIVU large unsigned operands
      drive(32'h0000_001B, 32'hFFFF_FFF0, 32'd7, 1'b0); tick;
`ifdef ALU_DIV_EN
      eh = 32'd2; el = 32'h2492_4922;
`endif
      checks++;
      if (hi !== eh || lo !== el) begin
         errors++; $display("FAIL divu: hi=%h lo=%h expected=%h %h", hi, lo, eh, el);
      end
   endtask

   task automatic test_reset_priority;
      drive(32'h0000_0011, 32'hABCD_0000, 32'd0, 1'b0); tick;
      checks++;
      if (hi !== 32'hABCD_0000) begin
         errors++; $display("FAIL mthi: hi=%h expected=abcd0000", hi);
      end
      drive(32'h0000_0010, 32'd0, 32'd0, 1'b1);
      checks++;
      if (alu_out !== 32'hABCD_0000) begin
         errors++; $display("FAIL mfhi_in_reset: alu_out=%h expected=abcd0000", alu_out);
      end
      drive(32'h0000_0013, 32'h1234_5678, 32'd0, 1'b1); tick;
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL reset_prio: hi=%h lo=%h expected=0 0", hi, lo);
      end
      drive(32'h0000_0010, 32'd0, 32'd0, 1'b0);
      checks++;
      if (alu_out !== 32'd0 || zero !== 1'b1) begin
         errors++; $display("FAIL mfhi_after_reset: alu_out=%h zero=%b expected=0 1", alu_out, zero);
      end
   endtask

   task automatic test_back_to_back;
      drive(32'h0000_0013, 32'h5555_AAAA, 32'd0, 1'b0); tick;
      drive(32'h0000_0011, 32'h0F0F_0F0F, 32'd0, 1'b0);
      checks++;
      if (hi !== 32'd0) begin
         errors++; $display("FAIL mthi_before_edge: hi=%h expected=0", hi);
      end
      tick;
      checks++;
      if (hi !== 32'h0F0F_0F0F || lo !== 32'h5555_AAAA) begin
         errors++; $display("FAIL mt_pair: hi=%h lo=%h expected=0f0f0f0f 5555aaaa", hi, lo);
      end
      drive(32'h0000_0012, 32'd0, 32'd0, 1'b0);
      checks++;
      if (alu_out !== 32'h5555_AAAA) begin
         errors++; $display("FAIL mflo: alu_out=%h expected=5555aaaa", alu_out);
      end
      tick;
      checks++;
      if (hi !== 32'h0F0F_0F0F || lo !== 32'h5555_AAAA) begin
         errors++; $display("FAIL mflo_nowrite: hi=%h lo=%h expected=0f0f0f0f 5555aaaa", hi, lo);
      end
   endtask

   task automatic test_random;
      logic [31:0] ins, a, b, w, nh, nl;
      logic [32:0] r;
      logic        rst_v;
      int          sel;
      drive(32'd0, 32'd0, 32'd0, 1'b1); tick;
      m_hi = 32'd0;
      m_lo = 32'd0;
      for (int n = 0; n < 800; n++) begin
         w   = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0)
            ins = w;
         else if (sel < 6)
            ins = {6'd0, w[25:6], rfuncts[$urandom_range(0, 24)]};
         else
            ins = {iops[$urandom_range(0, 15)], w[25:0]};
         a = pick_operand();
         b = pick_operand();
         if ($urandom_range(0, 7) == 0) b = a;
         rst_v = ($urandom_range(0, 39) == 0);
         drive(ins, a, b, rst_v);
         r = ref_comb(ins, a, b, m_hi, m_lo);
         checks++;
         if (alu_out !== r[31:0]) begin
            errors++; $display("FAIL rand_out ins=%h a=%h b=%h: alu_out=%h expected=%h", ins, a, b, alu_out, r[31:0]);
         end
         checks++;
         if (zero !== (r[31:0] == 32'd0)) begin
            errors++; $display("FAIL rand_zero ins=%h: zero=%b expected=%b", ins, zero, (r[31:0] == 32'd0));
         end
         checks++;
         if (i_type_ALUSrc !== r[32]) begin
            errors++; $display("FAIL rand_src ins=%h: ALUSrc=%b expected=%b", ins, i_type_ALUSrc, r[32]);
         end
         ref_next(ins, a, b, rst_v, m_hi, m_lo, nh, nl);
         tick;
         m_hi = nh;
         m_lo = nl;
         checks++;
         if (hi !== m_hi || lo !== m_lo) begin
            errors++; $display("FAIL rand_hilo ins=%h a=%h b=%h rst=%b: hi=%h lo=%h expected=%h %h",
                               ins, a, b, rst_v, hi, lo, m_hi, m_lo);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      instruction = 32'd0;
      alu_a       = 32'd0;
      alu_b       = 32'd0;
      test_reset;
      test_directed;
      test_mult;
      test_div;
      test_reset_priority;
      test_back_to_back;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
